// File: rtl/daa_pkg.sv
// Shared types and elaboration checks for the dynamic-alignment Booth MAC.
package daa_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        BUSY   = 2'd1,
        OUT    = 2'd2
    } daa_state_e;

    // Radix-4 Booth digit: sign plus one-hot magnitude (x1 => |d|=1, x2 => |d|=2, neither => 0)
    typedef struct packed {
        logic neg;
        logic x1;
        logic x2;
    } booth_digit_t;

    function automatic bit daa_widths_ok(int acc_w, int in_w, int w_w);
        return (acc_w >= in_w + w_w + 2) && (w_w >= 2) && ((w_w % 2) == 0);
    endfunction

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth recoder: weight triplet {w[2k+1], w[2k], w[2k-1]} to sign and one-hot magnitude.
module booth_r4_digit (
    input  logic [2:0] i_trip,
    output logic       o_neg,
    output logic       o_x1,
    output logic       o_x2
);

    always_comb begin
        o_neg = 1'b0;
        o_x1  = 1'b0;
        o_x2  = 1'b0;
        case (i_trip)
            3'b001, 3'b010: o_x1 = 1'b1;
            3'b011:         o_x2 = 1'b1;
            3'b100: begin
                o_neg = 1'b1;
                o_x2  = 1'b1;
            end
            3'b101, 3'b110: begin
                o_neg = 1'b1;
                o_x1  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/daa_booth_mac.sv
// Dynamic-alignment MAC: one radix-4 Booth digit per cycle, shared right-shift exponent on overflow.
// Sticky inexact tracking is generated only when DAA_STICKY_EN is defined; otherwise o_inexact is 0.
//   state  | meaning
//   ACCEPT | in_ready high, waiting for a term
//   BUSY   | applying Booth digits k = 0..ND-1 of the latched term
//   OUT    | o_valid high, result held until o_ready
module daa_booth_mac
    import daa_pkg::*;
#(
    parameter int IN_W  = 4,
    parameter int W_W   = 4,
    parameter int ACC_W = 10,
    parameter int EXP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic             in_sign_x,
    input  logic [W_W-1:0]   in_w,
    input  logic             in_last,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [ACC_W-1:0] o_acc,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_sat,
    output logic             o_inexact
);

    localparam int ND   = W_W / 2;
    localparam int K_W  = (ND > 1) ? $clog2(ND) : 1;
    localparam int SH_W = ((K_W + 1 > EXP_W) ? K_W + 1 : EXP_W) + 1;
    localparam logic [EXP_W-1:0]        MAX_EXP = '1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    generate
        if (!daa_widths_ok(ACC_W, IN_W, W_W)) begin : g_width_check
            $error("daa_booth_mac: W_W must be even and ACC_W >= IN_W+W_W+2");
        end
    endgenerate

    daa_state_e              r_state;
    logic [K_W-1:0]          r_k;
    logic signed [IN_W:0]    r_x;
    logic [W_W-1:0]          r_w;
    logic                    r_last;
    logic signed [ACC_W-1:0] r_acc;
    logic [EXP_W-1:0]        r_exp;
    logic                    r_sat;
    logic                    r_in_ready;
    logic                    r_o_valid;

    logic [W_W:0]            w_w_ext;
    logic [2:0]              w_trip;
    logic                    w_neg;
    logic                    w_x1;
    logic                    w_x2;
    booth_digit_t            w_digit;
    logic signed [ACC_W:0]   w_x_wide;
    logic signed [ACC_W:0]   w_mag;
    logic signed [ACC_W:0]   w_pp;
    logic signed [ACC_W:0]   w_pp_al;
    logic signed [ACC_W:0]   w_sum;
    logic [SH_W-1:0]         w_two_k;
    logic [SH_W-1:0]         w_exp_ext;
    logic [SH_W-1:0]         w_amt;
    logic                    w_left;
    logic                    w_ovf;
    logic                    w_last_digit;

    // A zero appended below the weight supplies w[-1] for digit 0
    assign w_w_ext = {r_w, 1'b0};
    assign w_trip  = 3'(w_w_ext >> {r_k, 1'b0});

    booth_r4_digit u_digit (
        .i_trip (w_trip),
        .o_neg  (w_neg),
        .o_x1   (w_x1),
        .o_x2   (w_x2)
    );

    assign w_digit   = {w_neg, w_x1, w_x2};
    assign w_x_wide  = {{(ACC_W-IN_W){r_x[IN_W]}}, r_x};
    assign w_mag     = w_digit.x2 ? (w_x_wide <<< 1) : (w_digit.x1 ? w_x_wide : '0);
    assign w_pp      = w_digit.neg ? -w_mag : w_mag;

    // Digit weight 4^k against the shared exponent: net shift is 2k - exp
    assign w_two_k   = SH_W'({r_k, 1'b0});
    assign w_exp_ext = SH_W'(r_exp);
    assign w_left    = (w_two_k >= w_exp_ext);
    assign w_amt     = w_left ? (w_two_k - w_exp_ext) : (w_exp_ext - w_two_k);
    assign w_pp_al   = w_left ? (w_pp <<< w_amt) : (w_pp >>> w_amt);
    assign w_sum     = {r_acc[ACC_W-1], r_acc} + w_pp_al;
    assign w_ovf     = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    assign w_last_digit = (r_k == K_W'(ND - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ACCEPT;
            r_k        <= '0;
            r_x        <= '0;
            r_w        <= '0;
            r_last     <= 1'b0;
            r_acc      <= '0;
            r_exp      <= '0;
            r_sat      <= 1'b0;
            r_in_ready <= 1'b1;
            r_o_valid  <= 1'b0;
        end else if (clear) begin
            r_state    <= ACCEPT;
            r_k        <= '0;
            r_acc      <= '0;
            r_exp      <= '0;
            r_sat      <= 1'b0;
            r_in_ready <= 1'b1;
            r_o_valid  <= 1'b0;
        end else begin
            case (r_state)
                ACCEPT: begin
                    if (in_valid) begin
                        r_x        <= in_sign_x ? {in_x[IN_W-1], in_x} : {1'b0, in_x};
                        r_w        <= in_w;
                        r_last     <= in_last;
                        r_k        <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (!w_ovf) begin
                        r_acc <= w_sum[ACC_W-1:0];
                    end else if (r_exp != MAX_EXP) begin
                        r_acc <= w_sum[ACC_W:1];
                        r_exp <= r_exp + EXP_W'(1);
                    end else begin
                        r_acc <= w_sum[ACC_W] ? ACC_MIN : ACC_MAX;
                        r_sat <= 1'b1;
                    end
                    if (w_last_digit) begin
                        if (r_last) begin
                            r_o_valid <= 1'b1;
                            r_state   <= OUT;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ACCEPT;
                        end
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                OUT: begin
                    if (o_ready) begin
                        r_acc      <= '0;
                        r_exp      <= '0;
                        r_sat      <= 1'b0;
                        r_o_valid  <= 1'b0;
                        r_in_ready <= 1'b1;
                        r_state    <= ACCEPT;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_o_valid  <= 1'b0;
                    r_state    <= ACCEPT;
                end
            endcase
        end
    end

`ifdef DAA_STICKY_EN
    logic [ACC_W:0] w_mask;
    logic           w_pp_lost;
    logic           w_renorm_lost;
    logic           r_inexact;

    assign w_mask        = ~({(ACC_W+1){1'b1}} << w_amt);
    assign w_pp_lost     = !w_left && (|(w_pp & w_mask));
    assign w_renorm_lost = w_ovf && (r_exp != MAX_EXP) && w_sum[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inexact <= 1'b0;
        end else if (clear) begin
            r_inexact <= 1'b0;
        end else if (r_state == BUSY) begin
            r_inexact <= r_inexact | w_pp_lost | w_renorm_lost;
        end else if ((r_state == OUT) && o_ready) begin
            r_inexact <= 1'b0;
        end
    end

    assign o_inexact = r_inexact;
`else
    assign o_inexact = 1'b0;
`endif

    assign in_ready = r_in_ready;
    assign o_valid  = r_o_valid;
    assign o_acc    = r_acc;
    assign o_exp    = r_exp;
    assign o_sat    = r_sat;

endmodule

// File: tb/tb_daa_booth_mac.sv
// Randomized and directed bench for daa_booth_mac against an arithmetic reference of the dot product.
module tb_daa_booth_mac;

    localparam int IN_W    = 4;
    localparam int W_W     = 4;
    localparam int ACC_W   = 10;
    localparam int EXP_W   = 3;
    localparam int ND      = W_W / 2;
    localparam int MAX_EXP = (1 << EXP_W) - 1;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));
`ifdef DAA_STICKY_EN
    localparam int STICKY = 1;
`else
    localparam int STICKY = 0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    clear;
    logic                    in_valid;
    logic                    in_ready;
    logic [IN_W-1:0]         in_x;
    logic                    in_sign_x;
    logic [W_W-1:0]          in_w;
    logic                    in_last;
    logic                    o_valid;
    logic                    o_ready;
    logic signed [ACC_W-1:0] o_acc;
    logic [EXP_W-1:0]        o_exp;
    logic                    o_sat;
    logic                    o_inexact;

    int n_vec  = 0;
    int n_miss = 0;

    int m_acc;
    int m_exp;
    int m_sat;
    int m_inx;

    always #5 clk = ~clk;

    daa_booth_mac #(
        .IN_W  (IN_W),
        .W_W   (W_W),
        .ACC_W (ACC_W),
        .EXP_W (EXP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_sign_x (in_sign_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_acc     (o_acc),
        .o_exp     (o_exp),
        .o_sat     (o_sat),
        .o_inexact (o_inexact)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int fdiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_clear();
        m_acc = 0;
        m_exp = 0;
        m_sat = 0;
        m_inx = 0;
    endtask

    // Term value = sum_k d_k * x * 4^k, each digit aligned to the current exponent
    task automatic model_term(input logic [IN_W-1:0] x, input logic sx, input logic [W_W-1:0] w);
        int xv, d, pp, al, s, den, sum;
        logic [W_W:0] wb;
        xv = sx ? int'($signed(x)) : int'(x);
        wb = {w, 1'b0};
        for (int k = 0; k < ND; k++) begin
            d  = int'(wb[2*k]) + int'(wb[2*k+1]) - 2 * int'(wb[2*k+2]);
            pp = d * xv;
            s  = 2 * k - m_exp;
            if (s >= 0) begin
                al = pp * (1 << s);
            end else begin
                den = 1 << (-s);
                al  = fdiv(pp, den);
                if (al * den != pp) m_inx = 1;
            end
            sum = m_acc + al;
            if (sum > ACC_MAX || sum < ACC_MIN) begin
                if (m_exp < MAX_EXP) begin
                    if ((sum % 2) != 0) m_inx = 1;
                    m_acc = fdiv(sum, 2);
                    m_exp = m_exp + 1;
                end else begin
                    m_acc = (sum > 0) ? ACC_MAX : ACC_MIN;
                    m_sat = 1;
                end
            end else begin
                m_acc = sum;
            end
        end
    endtask

    task automatic send_term(input logic [IN_W-1:0] x, input logic sx, input logic [W_W-1:0] w,
                             input logic last);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", 0, 1);
            return;
        end
        in_valid  = 1'b1;
        in_x      = x;
        in_sign_x = sx;
        in_w      = w;
        in_last   = last;
        @(negedge clk);
        in_valid  = 1'b0;
        in_x      = IN_W'($urandom);
        in_w      = W_W'($urandom);
        in_sign_x = 1'($urandom);
        in_last   = 1'($urandom);
        model_term(x, sx, w);
    endtask

    task automatic wait_valid(input string tag);
        int t;
        t = 0;
        while (!o_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!o_valid) chk({tag, "_valid_wait"}, 0, 1);
    endtask

    task automatic get_result(input string tag);
        wait_valid(tag);
        chk({tag, "_acc"}, o_acc, m_acc);
        chk({tag, "_exp"}, o_exp, m_exp);
        chk({tag, "_sat"}, o_sat, m_sat);
        chk({tag, "_inexact"}, o_inexact, (STICKY != 0) ? m_inx : 0);
        chk({tag, "_in_ready_out"}, in_ready, 0);
        o_ready = 1'b1;
        @(negedge clk);
        o_ready = 1'b0;
        chk({tag, "_valid_drop"}, o_valid, 0);
        chk({tag, "_acc_zero"}, o_acc, 0);
        model_clear();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_acc"}, o_acc, 0);
        chk({tag, "_exp"}, o_exp, 0);
        chk({tag, "_sat"}, o_sat, 0);
        chk({tag, "_inexact"}, o_inexact, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_sign_x = 1'b0;
        in_w      = '0;
        in_last   = 1'b0;
        o_ready   = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 3 * 5, two-cycle latency
        send_term(4'd3, 1'b1, 4'd5, 1'b1);
        chk("lat_n0_valid", o_valid, 0);
        @(negedge clk);
        chk("lat_n1_valid", o_valid, 0);
        chk("lat_n1_ready", in_ready, 0);
        @(negedge clk);
        chk("lat_n2_valid", o_valid, 1);
        chk("basic_acc_15", o_acc, 15);
        get_result("basic");

        // eight (-8)*(-8) terms: 512 overflows once
        for (int i = 0; i < 8; i++) send_term(4'h8, 1'b1, 4'h8, i == 7);
        wait_valid("ovf");
        chk("ovf_acc_256", o_acc, 256);
        chk("ovf_exp_1", o_exp, 1);
        get_result("ovf");

        send_term(4'hF, 1'b0, 4'd1, 1'b1);
        wait_valid("unsigned");
        chk("unsigned_acc_15", o_acc, 15);
        get_result("unsigned");

        send_term(4'hF, 1'b1, 4'd1, 1'b1);
        wait_valid("signed");
        chk("signed_acc_m1", o_acc, -1);
        get_result("signed");

        // exp=1 then x=1,w=1 loses its only bit
        for (int i = 0; i < 8; i++) send_term(4'h8, 1'b1, 4'h8, 1'b0);
        send_term(4'd1, 1'b1, 4'd1, 1'b1);
        wait_valid("sticky");
        chk("sticky_exp_1", o_exp, 1);
        chk("sticky_flag", o_inexact, STICKY);
        get_result("sticky");

        // consumer stall
        send_term(4'd3, 1'b1, 4'd5, 1'b1);
        wait_valid("hold");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", o_valid, 1);
            chk("hold_acc", o_acc, 15);
            chk("hold_ready", in_ready, 0);
        end
        get_result("hold");
        send_term(4'd2, 1'b1, 4'd3, 1'b1);
        wait_valid("after_hold");
        chk("after_hold_acc_6", o_acc, 6);
        get_result("after_hold");

        // drive negative terms until the exponent is exhausted and the mantissa clips
        for (int i = 0; i < 900; i++) send_term(4'hF, 1'b0, 4'h8, i == 899);
        wait_valid("sat");
        chk("sat_flag", o_sat, 1);
        chk("sat_exp_7", o_exp, 7);
        chk("sat_acc_min", o_acc, -512);
        get_result("sat");

        // clear mid-BUSY after exp has grown
        for (int i = 0; i < 8; i++) send_term(4'h8, 1'b1, 4'h8, 1'b0);
        send_term(4'd3, 1'b1, 4'd5, 1'b0);
        chk("clr_busy_ready", in_ready, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk_zero("clear");
        model_clear();
        send_term(4'd3, 1'b1, 4'd5, 1'b1);
        wait_valid("post_clear");
        chk("post_clear_acc_15", o_acc, 15);
        get_result("post_clear");

        // async reset mid-BUSY
        for (int i = 0; i < 6; i++) send_term(4'hF, 1'b0, 4'h8, 1'b0);
        send_term(4'd3, 1'b1, 4'd5, 1'b0);
        rst = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        send_term(4'd3, 1'b1, 4'd5, 1'b1);
        wait_valid("post_rst");
        chk("post_rst_acc_15", o_acc, 15);
        get_result("post_rst");

        for (int d = 0; d < 40; d++) begin
            n = $urandom_range(1, 6);
            for (int t = 0; t < n; t++) begin
                send_term(IN_W'($urandom), 1'($urandom), W_W'($urandom), t == n - 1);
            end
            wait_valid("rnd");
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk("rnd_hold_valid", o_valid, 1);
            end
            get_result("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
